// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
// Single-entry registered response buffer with valid/ready backpressure.
module alu_arbiter #(
  parameter int TAG_W     = 4,
  parameter int CNT_W     = 16,
  parameter int PRIO_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_out,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_COPY = 4'd10;
  localparam logic       PRIO_RST = (PRIO_INIT != 0);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state, state_next;
  logic       prio;
  logic       gnt_valid, gnt_id;
  logic       can_accept, accept;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        op_legal;
  logic [TAG_W-1:0] gnt_tag;

  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = prio;
    else                          gnt_id = !req0_valid;
  end

  assign can_accept = (state == EMPTY) | rsp_ready;
  assign accept     = gnt_valid & can_accept & !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (rsp_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid  = (state == FULL);
    req0_ready = accept & (gnt_id == 1'b0);
    req1_ready = accept & (gnt_id == 1'b1);
  end

  always_comb begin
    alu_a   = gnt_id ? req1_a   : req0_a;
    alu_b   = gnt_id ? req1_b   : req0_b;
    alu_op  = gnt_id ? req1_op  : req0_op;
    gnt_tag = gnt_id ? req1_tag : req0_tag;
  end

  always_comb begin
    alu_out  = 32'd0;
    op_legal = 1'b1;
    case (alu_op)
      ALU_ADD:  alu_out = alu_a + alu_b;
      ALU_SUB:  alu_out = alu_a - alu_b;
      ALU_AND:  alu_out = alu_a & alu_b;
      ALU_OR:   alu_out = alu_a | alu_b;
      ALU_XOR:  alu_out = alu_a ^ alu_b;
      ALU_SLT:  alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_out = {31'd0, alu_a < alu_b};
      ALU_SLL:  alu_out = alu_a << alu_b[4:0];
      ALU_SRL:  alu_out = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_out = 32'($signed(alu_a) >>> alu_b[4:0]);
      ALU_COPY: alu_out = alu_b;
      default:  op_legal = 1'b0;
    endcase
  end

  // Undefined ops force a zero result so no stale ALU value leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_out  <= 32'd0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_tag  <= '0;
      rsp_id   <= 1'b0;
      prio     <= PRIO_RST;
    end else if (accept) begin
      rsp_out  <= op_legal ? alu_out : 32'd0;
      rsp_zero <= op_legal ? (alu_out == 32'd0) : 1'b1;
      rsp_err  <= !op_legal;
      rsp_tag  <= gnt_tag;
      rsp_id   <= gnt_id;
      prio     <= !gnt_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SLL = 4'd7,
                         OP_SRL = 4'd8, OP_SRA = 4'd9, OP_COPY = 4'd10, OP_XXX = 4'd15;

  typedef struct packed {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] out;
    logic        zero;
    logic        err;
  } rsp_t;

  logic clk, rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op, req0_tag, req1_tag;
  logic rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [3:0] rsp_tag;
  logic [31:0] rsp_out;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic s_r0, s_r1, s_valid, s_id, s_zero, s_err;
  logic [3:0] s_tag;
  logic [31:0] s_out;
  logic [1:0] s_cnt0, s_cnt1;

  rsp_t rsp_act;
  assign rsp_act = {rsp_id, rsp_tag, rsp_out, rsp_zero, rsp_err};

  alu_arbiter #(.TAG_W(4), .CNT_W(16), .PRIO_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  alu_arbiter #(.TAG_W(4), .CNT_W(2), .PRIO_INIT(0)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(s_r0), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(s_r1), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .rsp_valid(s_valid), .rsp_ready(rsp_ready), .rsp_id(s_id), .rsp_tag(s_tag),
    .rsp_out(s_out), .rsp_zero(s_zero), .rsp_err(s_err),
    .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  rsp_t q[$];
  logic m_prio;
  logic e_r0, e_r1;
  int   m_cnt0, m_cnt1;

  function automatic rsp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic [3:0] tag);
    rsp_t r;
    logic [63:0] ext;
    logic [31:0] o;
    logic legal;
    legal = 1'b1;
    ext = {{32{a[31]}}, a};
    case (op)
      OP_ADD:  o = a + b;
      OP_SUB:  o = a + ~b + 32'd1;
      OP_AND:  o = a & b;
      OP_OR:   o = a | b;
      OP_XOR:  o = a ^ b;
      OP_SLT:  o = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      OP_SLTU: o = {31'd0, a < b};
      OP_SLL:  o = a << b[4:0];
      OP_SRL:  o = a >> b[4:0];
      OP_SRA:  begin ext = ext >> b[4:0]; o = ext[31:0]; end
      OP_COPY: o = b;
      default: begin o = 32'd0; legal = 1'b0; end
    endcase
    r.id = id; r.tag = tag; r.out = o; r.zero = (o == 32'd0); r.err = !legal;
    return r;
  endfunction

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [3:0] tag);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_tag = tag;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [3:0] tag);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_tag = tag;
  endtask

  // Settle combinational paths and compute the expected grant for this cycle.
  task automatic plan();
    logic can, g;
    #1;
    can = (q.size() == 0) || rsp_ready;
    g = (req0_valid && req1_valid) ? m_prio : !req0_valid;
    e_r0 = can && (req0_valid || req1_valid) && !g && !rst;
    e_r1 = can && (req0_valid || req1_valid) && g && !rst;
  endtask

  task automatic edge_step();
    if (rsp_ready && q.size() > 0) void'(q.pop_front());
    if (e_r0) begin
      q.push_back(model(1'b0, req0_a, req0_b, req0_op, req0_tag));
      m_prio = 1'b1; m_cnt0++;
    end else if (e_r1) begin
      q.push_back(model(1'b1, req1_a, req1_b, req1_op, req1_tag));
      m_prio = 1'b0; m_cnt1++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b1;
    set0(1'b1, 32'd1, 32'd2, OP_ADD, 4'd1);
    set1(1'b1, 32'd3, 32'd4, OP_ADD, 4'd2);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_act !== '0) begin
      errors++; $display("FAIL reset_rsp valid=%b rsp=%h want 0", rsp_valid, rsp_act);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready r0=%b r1=%b want 0", req0_ready, req1_ready);
    end
    checks++;
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      errors++; $display("FAIL reset_cnt c0=%0d c1=%0d want 0", grant_cnt0, grant_cnt1);
    end
    set0(1'b0, 0, 0, OP_ADD, 0); set1(1'b0, 0, 0, OP_ADD, 0);
    rst = 1'b0;
    q.delete(); m_prio = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set0(1'b1, 32'(i), 32'd100, OP_ADD, 4'(i));
      set1(1'b1, 32'(i * 3), 32'd1, OP_SUB, 4'(i + 8));
      plan();
      checks++;
      if (req0_ready !== ((i % 2) == 0) || req1_ready !== ((i % 2) == 1) ||
          req0_ready !== e_r0 || req1_ready !== e_r1) begin
        errors++; $display("FAIL contention_grant[%0d] r0=%b r1=%b want %b %b",
                           i, req0_ready, req1_ready, (i % 2) == 0, (i % 2) == 1);
      end
      edge_step();
      checks++;
      if (q.size() != 1 || rsp_valid !== 1'b1 || rsp_act !== q[0]) begin
        errors++; $display("FAIL contention_rsp[%0d] valid=%b rsp=%h", i, rsp_valid, rsp_act);
      end
    end
    set0(1'b0, 0, 0, OP_ADD, 0); set1(1'b0, 0, 0, OP_ADD, 0);
    plan(); edge_step();
    checks++;
    if (grant_cnt0 !== 16'd3 || grant_cnt1 !== 16'd3 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL contention_cnt c0=%0d c1=%0d valid=%b want 3 3 0",
                         grant_cnt0, grant_cnt1, rsp_valid);
    end
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set0(1'b1, 32'd5, 32'd7, OP_ADD, 4'd3);
    plan();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    edge_step();
    set0(1'b0, 0, 0, OP_ADD, 0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_act !== rsp_t'({1'b0, 4'd3, 32'd12, 1'b0, 1'b0}) ||
        q.size() != 1 || rsp_act !== q[0]) begin
      errors++; $display("FAIL single_rsp valid=%b rsp=%h want id0 tag3 out12", rsp_valid, rsp_act);
    end
    plan(); edge_step();
  endtask

  task automatic test_backpressure();
    rsp_t held;
    rsp_ready = 1'b1;
    set1(1'b1, 32'd9, 32'd9, OP_SUB, 4'd6);
    plan(); edge_step();
    set1(1'b0, 0, 0, OP_ADD, 0);
    held = {1'b1, 4'd6, 32'd0, 1'b1, 1'b0};
    checks++;
    if (rsp_valid !== 1'b1 || rsp_act !== held) begin
      errors++; $display("FAIL bp_first valid=%b rsp=%h want %h", rsp_valid, rsp_act, held);
    end
    rsp_ready = 1'b0;
    set0(1'b1, 32'hA, 32'h3, OP_XOR, 4'd9);
    for (int i = 0; i < 3; i++) begin
      plan();
      checks++;
      if (req0_ready !== 1'b0 || e_r0 !== 1'b0) begin
        errors++; $display("FAIL bp_stall_ready[%0d] r0=%b want 0", i, req0_ready);
      end
      edge_step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_act !== held) begin
        errors++; $display("FAIL bp_hold[%0d] rsp=%h want %h", i, rsp_act, held);
      end
    end
    rsp_ready = 1'b1;
    plan();
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready r0=%b want 1", req0_ready);
    end
    edge_step();
    set0(1'b0, 0, 0, OP_ADD, 0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_act !== rsp_t'({1'b0, 4'd9, 32'h9, 1'b0, 1'b0}) ||
        q.size() != 1 || rsp_act !== q[0]) begin
      errors++; $display("FAIL bp_next valid=%b rsp=%h want out 9 tag 9", rsp_valid, rsp_act);
    end
    plan(); edge_step();
  endtask

  task automatic test_ops();
    logic [31:0] ta[16];
    logic [31:0] tb[16];
    logic [3:0]  top[16];
    ta[0] = 32'h80000000; tb[0] = 32'd4;        top[0] = OP_SRA;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'd1;        top[1] = OP_SLT;
    ta[2] = 32'hFFFFFFFF; tb[2] = 32'd1;        top[2] = OP_SLTU;
    ta[3] = 32'h12345678; tb[3] = 32'd9;        top[3] = OP_XXX;
    ta[4] = 32'hFFFFFFFF; tb[4] = 32'd1;        top[4] = OP_ADD;
    ta[5] = 32'd0;        tb[5] = 32'd1;        top[5] = OP_SUB;
    ta[6] = 32'hF0F0F0F0; tb[6] = 32'h0FF00FF0; top[6] = OP_AND;
    ta[7] = 32'hF0F0F0F0; tb[7] = 32'h0FF00FF0; top[7] = OP_OR;
    ta[8] = 32'h00000001; tb[8] = 32'h0000003F; top[8] = OP_SLL;
    ta[9] = 32'h80000000; tb[9] = 32'h00000021; top[9] = OP_SRL;
    ta[10] = 32'h5;       tb[10] = 32'hDEADBEEF; top[10] = OP_COPY;
    ta[11] = 32'h5;       tb[11] = 32'h6;       top[11] = 4'd11;
    for (int i = 12; i < 16; i++) begin
      ta[i] = $urandom; tb[i] = $urandom; top[i] = 4'($urandom_range(0, 10));
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set0(1'b1, ta[i], tb[i], top[i], 4'(i));
      plan(); edge_step();
      checks++;
      if (q.size() != 1 || rsp_valid !== 1'b1 || rsp_act !== q[0]) begin
        errors++; $display("FAIL op[%0d] op=%0d rsp=%h want %h", i, top[i], rsp_act,
                           q.size() ? q[0] : rsp_t'('0));
      end
      if (i == 0) begin
        checks++;
        if (rsp_out !== 32'hF8000000) begin
          errors++; $display("FAIL op_sra out=%h want f8000000", rsp_out);
        end
      end
      if (i == 1 || i == 2) begin
        checks++;
        if (rsp_out !== ((i == 1) ? 32'd1 : 32'd0)) begin
          errors++; $display("FAIL op_slt[%0d] out=%h want %0d", i, rsp_out, i == 1);
        end
      end
      if (i == 3) begin
        checks++;
        if (rsp_err !== 1'b1 || rsp_out !== 32'd0 || rsp_zero !== 1'b1) begin
          errors++; $display("FAIL op_xxx err=%b out=%h zero=%b want 1 0 1", rsp_err, rsp_out, rsp_zero);
        end
      end
    end
    set0(1'b0, 0, 0, OP_ADD, 0);
    plan(); edge_step();
  endtask

  task automatic test_async_reset_and_sat();
    rsp_ready = 1'b1;
    set0(1'b1, 32'd1, 32'd1, OP_ADD, 4'd2);
    plan(); edge_step();
    set0(1'b0, 0, 0, OP_ADD, 0);
    rsp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_act !== '0 || grant_cnt0 !== 16'd0) begin
      errors++; $display("FAIL async_reset valid=%b rsp=%h c0=%0d want 0", rsp_valid, rsp_act, grant_cnt0);
    end
    #1;
    rst = 1'b0;
    q.delete(); m_prio = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set0(1'b1, 32'd2, 32'd3, OP_OR, 4'd4);
    set1(1'b1, 32'd2, 32'd3, OP_AND, 4'd5);
    plan();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL post_reset_prio r0=%b r1=%b want 1 0", req0_ready, req1_ready);
    end
    edge_step();
    set1(1'b0, 0, 0, OP_ADD, 0);
    for (int i = 0; i < 4; i++) begin
      plan(); edge_step();
    end
    set0(1'b0, 0, 0, OP_ADD, 0);
    plan(); edge_step();
    checks++;
    if (s_cnt0 !== 2'd3 || grant_cnt0 !== 16'd5 || grant_cnt0 !== 16'(m_cnt0)) begin
      errors++; $display("FAIL saturation sat_c0=%0d c0=%0d want 3 5", s_cnt0, grant_cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_ops();
    test_async_reset_and_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
